// File: rtl/tbf_ch_pulser.sv
// Per-element transmit beamforming pulser: per-beam delay LUT, delay countdown,
// then a bipolar pulse train of programmable half-period and cycle count.
module tbf_ch_pulser #(
  parameter int ADDR_WD = 7,
  parameter int DLY_WD  = 12,
  parameter int HALF_WD = 6,
  parameter int CYC_WD  = 4
) (
  input  logic               clk,
  input  logic               rst_n,        // active-high despite the name
  input  logic [ADDR_WD-1:0] lut_addr,
  input  logic               lut_we,
  input  logic [DLY_WD-1:0]  lut_din,
  input  logic [ADDR_WD-1:0] beam_addr,
  input  logic [HALF_WD-1:0] half_period,
  input  logic [CYC_WD-1:0]  num_cycles,
  input  logic               fire,
  input  logic               abort,
  output logic               pulse_p,
  output logic               pulse_n,
  output logic               tx_active,
  output logic               tx_done,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DELAY   = 3'd2,
    PHASE_P = 3'd3,
    PHASE_N = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [DLY_WD-1:0]  mem [0:(1<<ADDR_WD)-1];
  logic [DLY_WD-1:0]  rd_data;
  logic [HALF_WD-1:0] half_q;

  logic [DLY_WD-1:0]  dly_cnt, dly_nxt;
  logic [HALF_WD-1:0] ph_cnt, ph_nxt;
  logic [CYC_WD-1:0]  cyc_cnt, cyc_nxt;

  logic fire_acc;
  logic abort_acc;

  // A zero half-period would never terminate a phase, so it is clamped to one.
  function automatic logic [HALF_WD-1:0] sat_half(input logic [HALF_WD-1:0] h);
    return (h == '0) ? HALF_WD'(1) : h;
  endfunction

  assign fire_acc  = fire  && (state == IDLE);
  assign abort_acc = abort && (state != IDLE);

  // Delay LUT (read-first on a same-address collision) and burst parameter latch
  always_ff @(posedge clk) begin
    if (lut_we) mem[lut_addr] <= lut_din;
    if (fire_acc) begin
      rd_data <= mem[beam_addr];
      half_q  <= sat_half(half_period);
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= IDLE;
      dly_cnt <= '0;
      ph_cnt  <= '0;
      cyc_cnt <= '0;
    end else begin
      state   <= state_nxt;
      dly_cnt <= dly_nxt;
      ph_cnt  <= ph_nxt;
      cyc_cnt <= cyc_nxt;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    ph_nxt    = ph_cnt;
    cyc_nxt   = cyc_cnt;
    if (abort_acc) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            state_nxt = LOAD;
            cyc_nxt   = num_cycles;
          end
        end
        LOAD: begin
          if (rd_data == '0) begin
            if (cyc_cnt == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt = PHASE_P;
              ph_nxt    = half_q;
            end
          end else begin
            state_nxt = DELAY;
            dly_nxt   = rd_data;
          end
        end
        DELAY: begin
          if (dly_cnt == DLY_WD'(1)) begin
            if (cyc_cnt == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt = PHASE_P;
              ph_nxt    = half_q;
            end
          end else begin
            dly_nxt = dly_cnt - DLY_WD'(1);
          end
        end
        PHASE_P: begin
          if (ph_cnt == HALF_WD'(1)) begin
            state_nxt = PHASE_N;
            ph_nxt    = half_q;
          end else begin
            ph_nxt = ph_cnt - HALF_WD'(1);
          end
        end
        PHASE_N: begin
          if (ph_cnt == HALF_WD'(1)) begin
            if (cyc_cnt == CYC_WD'(1)) begin
              state_nxt = DONE;
            end else begin
              state_nxt = PHASE_P;
              ph_nxt    = half_q;
              cyc_nxt   = cyc_cnt - CYC_WD'(1);
            end
          end else begin
            ph_nxt = ph_cnt - HALF_WD'(1);
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered outputs decoded from the current state; abort clears them at once
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pulse_p   <= 1'b0;
      pulse_n   <= 1'b0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      busy      <= 1'b0;
    end else if (abort_acc) begin
      pulse_p   <= 1'b0;
      pulse_n   <= 1'b0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pulse_p   <= (state == PHASE_P);
      pulse_n   <= (state == PHASE_N);
      tx_active <= (state == LOAD) || (state == DELAY) ||
                   (state == PHASE_P) || (state == PHASE_N);
      tx_done   <= (state == DONE);
      busy      <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_tbf_ch_pulser.sv
// Bench for tbf_ch_pulser: directed timing cases plus randomized bursts
// compared cycle by cycle against a burst-level timing model.
module tb_tbf_ch_pulser;

  localparam int BIG = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] lut_addr;
  logic       lut_we;
  logic [11:0] lut_din;
  logic [6:0] beam_addr;
  logic [5:0] half_period;
  logic [3:0] num_cycles;
  logic       fire;
  logic       abort;
  logic       pulse_p, pulse_n, tx_active, tx_done, busy;

  tbf_ch_pulser #(.ADDR_WD(7), .DLY_WD(12), .HALF_WD(6), .CYC_WD(4)) dut (
    .clk(clk), .rst_n(rst_n), .lut_addr(lut_addr), .lut_we(lut_we),
    .lut_din(lut_din), .beam_addr(beam_addr), .half_period(half_period),
    .num_cycles(num_cycles), .fire(fire), .abort(abort), .pulse_p(pulse_p),
    .pulse_n(pulse_n), .tx_active(tx_active), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: LUT image plus the timing of the most recent accepted burst.
  int mem_m [128];
  bit b_valid = 1'b0;
  int b_e, b_d, b_h, b_n, b_end;
  int b_abort = BIG;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // First edge at which the pulser is back in IDLE and can take a fire.
  function automatic int idle_from();
    return ((b_abort < b_end) ? b_abort : b_end) + 1;
  endfunction

  // Expected {pulse_p, pulse_n, tx_active, tx_done, busy} just after edge t.
  function automatic logic [4:0] exp_out(input int t);
    int r;
    logic p, n, a, d, b;
    p = 0; n = 0; a = 0; d = 0; b = 0;
    if (b_valid && t > b_e && t < b_abort) begin
      r = t - (b_e + 2 + b_d);
      if (r >= 0 && r < 2 * b_h * b_n) begin
        p = (r % (2 * b_h)) < b_h;
        n = !p;
      end
      a = (t <= b_end - 1);
      d = (t == b_end);
      b = (t <= b_end);
    end
    return {p, n, a, d, b};
  endfunction

  // One clock edge: advance the model with the inputs being sampled, then check.
  task automatic tick();
    bit idle_now;
    @(posedge clk);
    cyc++;
    idle_now = !b_valid || (cyc >= idle_from());
    if (!idle_now && abort) begin
      b_abort = cyc;
    end else if (idle_now && fire) begin
      b_valid = 1'b1;
      b_e     = cyc;
      b_d     = mem_m[beam_addr];
      b_h     = (half_period == 0) ? 1 : int'(half_period);
      b_n     = num_cycles;
      b_end   = cyc + 2 + b_d + 2 * b_h * b_n;
      b_abort = BIG;
    end
    if (lut_we) mem_m[lut_addr] = lut_din;
    #1;
    chk("wave", {pulse_p, pulse_n, tx_active, tx_done, busy}, exp_out(cyc));
    chk("excl", pulse_p & pulse_n, 0);
  endtask

  // Fire one burst and record times relative to the fire edge.
  task automatic measure(input int beam, input int h, input int n,
                         input int refire_at, input int abort_at, input int limit,
                         output int t_p, output int t_n, output int t_done,
                         output int np, output int nn, output logic [4:0] o_ab);
    int f;
    int rel;
    t_p = -1; t_n = -1; t_done = -1; np = 0; nn = 0; o_ab = '1;
    beam_addr = beam; half_period = h; num_cycles = n; fire = 1;
    tick();
    f = cyc; fire = 0; lut_we = 0;
    for (int k = 1; k <= limit; k++) begin
      if (k == refire_at) begin
        fire = 1; beam_addr = 0; half_period = 1; num_cycles = 1;
      end
      if (k == abort_at) abort = 1;
      tick();
      fire = 0; abort = 0;
      rel = cyc - f;
      if (pulse_p) begin np++; if (t_p < 0) t_p = rel; end
      if (pulse_n) begin nn++; if (t_n < 0) t_n = rel; end
      if (k == abort_at) o_ab = {pulse_p, pulse_n, tx_active, tx_done, busy};
      if (tx_done) begin t_done = rel; break; end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tp, tn, td, np, nn;
    logic [4:0] oab;
    rst_n = 1; lut_addr = 0; lut_we = 0; lut_din = 0; beam_addr = 0;
    half_period = 0; num_cycles = 0; fire = 0; abort = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {pulse_p, pulse_n, tx_active, tx_done, busy}, 0);
    rst_n = 0;

    // Fill the LUT: small random delays, with fixed entries for directed cases.
    for (int i = 0; i < 128; i++) begin
      lut_we = 1; lut_addr = i;
      lut_din = (i == 5) ? 12'd10 : (i == 7) ? 12'd0 : (i == 9) ? 12'd4095
                                  : 12'($urandom_range(15));
      tick();
    end
    lut_we = 0;

    // Basic burst with an ignored re-fire at T=5.
    measure(5, 4, 2, 5, -1, 40, tp, tn, td, np, nn, oab);
    chk("basic_p_rise", tp, 12);
    chk("basic_n_rise", tn, 16);
    chk("basic_done", td, 28);
    chk("basic_np", np, 8);
    chk("basic_nn", nn, 8);

    // Back-to-back: fire in the cycle after tx_done; D=0, H=0, N=1.
    measure(7, 0, 1, -1, -1, 20, tp, tn, td, np, nn, oab);
    chk("min_p_rise", tp, 2);
    chk("min_n_rise", tn, 3);
    chk("min_done", td, 4);
    chk("min_np", np, 1);

    // Maximum delay with no pulse cycles.
    measure(9, 3, 0, -1, -1, 4200, tp, tn, td, np, nn, oab);
    chk("maxd_done", td, 4097);
    chk("maxd_np", np + nn, 0);

    // Abort during the first positive phase.
    measure(5, 4, 2, -1, 15, 40, tp, tn, td, np, nn, oab);
    chk("abort_outs", oab, 0);
    chk("abort_no_done", td, -1);
    chk("abort_np", np, 3);
    measure(5, 2, 1, -1, -1, 40, tp, tn, td, np, nn, oab);
    chk("post_abort_p", tp, 12);
    chk("post_abort_done", td, 16);

    // LUT collision: write 20 to address 5 on the same edge fire reads it.
    lut_we = 1; lut_addr = 5; lut_din = 20;
    measure(5, 1, 1, -1, -1, 40, tp, tn, td, np, nn, oab);
    chk("coll_old_d", tp, 12);
    measure(5, 1, 1, -1, -1, 40, tp, tn, td, np, nn, oab);
    chk("coll_new_d", tp, 22);

    // Asynchronous reset while pulse_p is high.
    beam_addr = 5; half_period = 4; num_cycles = 2; fire = 1;
    tick();
    fire = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (pulse_p) break;
    end
    chk("pre_rst_p", pulse_p, 1);
    #3;
    rst_n = 1;
    #1;
    chk("rst_async", {pulse_p, pulse_n, tx_active, tx_done, busy}, 0);
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1;
    rst_n = 0;
    b_valid = 0;
    b_abort = BIG;
    measure(5, 1, 1, -1, -1, 40, tp, tn, td, np, nn, oab);
    chk("post_rst_p", tp, 22);
    chk("post_rst_done", td, 24);

    // Randomized bursts with ignored re-fires, occasional aborts and LUT writes.
    for (int b = 0; b < 1000; b++) begin
      int bm, h, n, heff, cp, cn, guard;
      bm = $urandom_range(127); if (bm == 9) bm = 10;
      h = $urandom_range(5); n = $urandom_range(3);
      heff = (h == 0) ? 1 : h;
      beam_addr = bm; half_period = h; num_cycles = n; fire = 1;
      tick();
      fire = 0;
      cp = 0; cn = 0; guard = 0;
      while (cyc + 1 < idle_from() && guard < 300) begin
        fire = ($urandom_range(15) == 0);
        beam_addr = 7'($urandom); half_period = 6'($urandom); num_cycles = 4'($urandom);
        abort = ($urandom_range(63) == 0);
        lut_we = ($urandom_range(7) == 0);
        lut_addr = 7'($urandom_range(127)); if (lut_addr == 9) lut_addr = 10;
        lut_din = 12'($urandom_range(15));
        tick();
        fire = 0; abort = 0; lut_we = 0;
        cp += pulse_p; cn += pulse_n;
        guard++;
      end
      if (b_abort == BIG) begin
        chk("rnd_np", cp, heff * n);
        chk("rnd_nn", cn, heff * n);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tbf_ch_pulser.md
# tbf_ch_pulser

Per-channel transmit beamforming pulser: the transmit-side counterpart of the receive DBF channel's coarse-delay path. It holds a per-beam transmit delay in a dual-port LUT. On a fire strobe it waits that many clocks and then drives a bipolar pulse train (pulse_p / pulse_n) of programmable half-period and cycle count. One instance sits per transducer element. The tx_active output gates the receive channel (drives its tx_en) for the duration of the burst.

## Interface
- ADDR_WD, 7, LUT address width (beam index); LUT depth 2^ADDR_WD
- DLY_WD, 12, transmit delay width, in clock cycles
- HALF_WD, 6, pulse half-period width, in clock cycles
- CYC_WD, 4, pulse cycle-count width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-high reset (high = reset, despite the name)
- lut_addr  in  ADDR_WD  LUT write address
- lut_we  in  1  LUT write enable
- lut_din  in  DLY_WD  LUT write data (delay for beam lut_addr)
- beam_addr  in  ADDR_WD  LUT read address; sampled with fire
- half_period  in  HALF_WD  half-period H; sampled with fire
- num_cycles  in  CYC_WD  number of full cycles N; sampled with fire
- fire  in  1  start-of-transmit strobe
- abort  in  1  synchronous burst abort
- pulse_p  out  1  positive pulser drive
- pulse_n  out  1  negative pulser drive
- tx_active  out  1  high while the burst is in progress
- tx_done  out  1  one-cycle strobe at the end of the burst
- busy  out  1  high whenever the state is not IDLE

## Operation
- Reset: state IDLE; all outputs 0; counters 0. LUT contents are not reset.
- LUT: synchronous single-write / single-read RAM.
  - Write when lut_we=1, at any time, including mid-burst.
  - Read is registered.
  - Same-cycle write and read of the same address returns the old data (read-first).
- FSM states: IDLE, LOAD, DELAY, PHASE_P, PHASE_N, DONE.
  - IDLE: fire=1 → LOAD. Latch beam_addr, H and N. Set tx_active=1.
  - LOAD: the LUT data D is valid; load the delay counter with D.
    - D=0 → PHASE_P directly.
    - Otherwise → DELAY.
    - N=0 skips the pulse phases and goes to DONE at the end of the delay.
  - DELAY: decrement each cycle; at the terminal count → PHASE_P, or → DONE if N=0.
  - PHASE_P: pulse_p=1 for H cycles, then → PHASE_N.
  - PHASE_N: pulse_n=1 for H cycles.
    - Then decrement the cycle counter: if cycles remain → PHASE_P, else → DONE.
  - DONE: one cycle. tx_done=1, tx_active=0 → IDLE.
- H=0 is treated as H=1.
- pulse_p and pulse_n are registered outputs and are never high in the same cycle.
- fire while busy=1 is ignored: no restart, and the latched parameters are unchanged.
- abort=1 in any non-IDLE state → IDLE on the next edge.
  - pulse_p, pulse_n and tx_active drop to 0 on that edge.
  - tx_done is not asserted.
  - abort has priority over fire in the same cycle.
  - abort in IDLE has no effect.
- The delay counter is DLY_WD bits and holds values up to 2^DLY_WD−1; it never wraps.

## Timing
- Fire sampled at edge k (T=0): tx_active=1 and busy=1 from k+1.
- LUT read: 1-cycle latency (LOAD state at k+1).
- pulse_p rises at edge k+2+D.
  - It stays high H cycles; then pulse_n is high H cycles; the pattern repeats N times.
- Last pulse_n falls at edge k+2+D+2HN. tx_done is high for that one cycle and tx_active falls on the same edge.
- N=0: tx_done at k+2+D, with no pulse activity.
- Earliest re-fire: fire sampled in the cycle after tx_done, which is the first IDLE cycle. Burst-to-burst gap is 0 idle cycles.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset mid-burst: assert rst_n during PHASE_P → pulse_p, pulse_n, tx_active, tx_done and busy all read 0 asynchronously; after release, fire works normally.
- Basic burst: write LUT[5]=10; fire with beam_addr=5, H=4, N=2 at T=0 → pulse_p high T=12..15, pulse_n high 16..19, pulse_p high 20..23, pulse_n high 24..27; tx_done at T=28; tx_active high T=1..27.
- Edge values: D=0, H=0, N=1 → pulse_p at T=2, pulse_n at T=3, tx_done at T=4. Also D=4095, N=0 → no pulses, tx_done at T=4097.
- Re-fire / abort: fire again at T=5 during a burst → timing unchanged. abort at T=14 → all outputs 0 at T=15, no tx_done, and the next fire is accepted.
- LUT collision: lut_we on address 5 with new value 20 in the same cycle fire reads address 5 → that burst uses the old D; the next burst uses D=20.
- Exclusivity check: random H, N, D over 1000 bursts → pulse_p & pulse_n is never 1; measured pulse widths and counts match H and N.
